// File: rtl/interrupt_controller.sv
// Interrupt responder: frame timer and keyboard capture arbitrated onto a single
// request/acknowledge/end handshake with the active processor.
module interrupt_controller #(
    parameter int FRAME_TICKS = 833333,
    parameter int CNT_W       = 20
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       KBD_STROBE,
    input  logic [7:0] KBD_CODE,
    input  logic [1:0] INT_MASK,
    output logic [1:0] INT_IRQ,
    input  logic       INT_IACK,
    input  logic       INT_IEND,
    output logic [7:0] KBD_KEY,
    output logic [7:0] FRAME_OVERRUN,
    output logic       KEY_DROP,
    output logic       PROTO_ERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [1:0] IRQ_FRAME = 2'b00;
    localparam logic [1:0] IRQ_KEY   = 2'b01;
    localparam logic [1:0] IRQ_NONE  = 2'b11;

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             frame_pend_reg;
    logic             key_pend_reg;
    logic [7:0]       key_buf_reg;
    logic [1:0]       irq_reg;
    logic [7:0]       kbd_key_reg;
    logic [7:0]       overrun_reg;
    logic             key_drop_reg;
    logic             proto_err_reg;

    logic tick;
    logic frame_eligible;
    logic key_eligible;
    logic take_key;
    logic clear_frame;

    assign tick           = (count_reg == CNT_W'(FRAME_TICKS - 1));
    assign frame_eligible = frame_pend_reg & ~INT_MASK[0];
    assign key_eligible   = key_pend_reg & ~INT_MASK[1];
    // Key buffer moves to KBD_KEY only when the frame does not win arbitration.
    assign take_key       = (state_reg == IDLE) && !frame_eligible && key_eligible;
    // A presented frame request stays pending until the processor acknowledges it.
    assign clear_frame    = (state_reg == ASSERT) && INT_IACK && (irq_reg == IRQ_FRAME);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            frame_pend_reg <= 1'b0;
            key_pend_reg   <= 1'b0;
            key_buf_reg    <= 8'h00;
            irq_reg        <= IRQ_NONE;
            kbd_key_reg    <= 8'h00;
            overrun_reg    <= 8'h00;
            key_drop_reg   <= 1'b0;
            proto_err_reg  <= 1'b0;
        end else begin
            count_reg <= tick ? '0 : count_reg + 1'b1;

            if (tick) begin
                frame_pend_reg <= 1'b1;
                if (frame_pend_reg && !clear_frame && overrun_reg != 8'hFF)
                    overrun_reg <= overrun_reg + 8'd1;
            end else if (clear_frame) begin
                frame_pend_reg <= 1'b0;
            end

            if (KBD_STROBE) begin
                key_buf_reg  <= KBD_CODE;
                key_pend_reg <= 1'b1;
                if (key_pend_reg && !take_key)
                    key_drop_reg <= 1'b1;
            end else if (take_key) begin
                key_pend_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (INT_IACK || INT_IEND)
                        proto_err_reg <= 1'b1;
                    if (frame_eligible) begin
                        irq_reg   <= IRQ_FRAME;
                        state_reg <= ASSERT;
                    end else if (key_eligible) begin
                        irq_reg     <= IRQ_KEY;
                        kbd_key_reg <= key_buf_reg;
                        state_reg   <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (INT_IEND)
                        proto_err_reg <= 1'b1;
                    if (INT_IACK) begin
                        irq_reg   <= IRQ_NONE;
                        state_reg <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (INT_IACK)
                        proto_err_reg <= 1'b1;
                    if (INT_IEND)
                        state_reg <= IDLE;
                end
                default: begin
                    irq_reg   <= IRQ_NONE;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign INT_IRQ       = irq_reg;
    assign KBD_KEY       = kbd_key_reg;
    assign FRAME_OVERRUN = overrun_reg;
    assign KEY_DROP      = key_drop_reg;
    assign PROTO_ERR     = proto_err_reg;

endmodule
